// File: rtl/write_back_arb.sv
// Registered write-back stage: merges fixed-latency exec results with queued L1 load returns.
// Optional WB_LD_BYPASS_EN: a load arriving at an empty queue on an idle cycle skips the queue.
module write_back_arb #(
  parameter int CONTROL_WIDTH = 21,
  parameter int R_DATA_WIDTH  = 32,
  parameter int IMM_WIDTH     = 16,
  parameter int NUM_LANES     = 8,
  parameter int WARP_BITS     = 5,
  parameter int REG_BITS      = 6,
  parameter int LD_Q_DEPTH    = 4,
  parameter int IMM_SEXT      = 0
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [CONTROL_WIDTH-1:0]            control_e,
  input  logic [NUM_LANES*R_DATA_WIDTH-1:0]   mult_e,
  input  logic [NUM_LANES*R_DATA_WIDTH-1:0]   add_e,
  input  logic [NUM_LANES*R_DATA_WIDTH-1:0]   shift_e,
  input  logic [NUM_LANES*R_DATA_WIDTH-1:0]   logical_e,
  input  logic [NUM_LANES*R_DATA_WIDTH-1:0]   compare_e,
  input  logic [NUM_LANES*R_DATA_WIDTH-1:0]   src1_e,
  input  logic [IMM_WIDTH-1:0]                imm_e,
  input  logic [R_DATA_WIDTH-1:0]             const_e,
  input  logic [NUM_LANES-1:0]                wmask_e,
  input  logic [WARP_BITS-1:0]                warp_e,
  input  logic [REG_BITS-1:0]                 rd_e,
  input  logic                                ld_valid_m,
  output logic                                ld_ready_wb,
  input  logic [NUM_LANES*R_DATA_WIDTH-1:0]   ld_data_m,
  input  logic [NUM_LANES-1:0]                ld_mask_m,
  input  logic [WARP_BITS-1:0]                ld_warp_m,
  input  logic [REG_BITS-1:0]                 ld_rd_m,
  output logic [NUM_LANES*R_DATA_WIDTH-1:0]   rdata_wb,
  output logic [NUM_LANES-1:0]                rwe_wb,
  output logic [WARP_BITS-1:0]                rwarp_wb,
  output logic [REG_BITS-1:0]                 raddr_wb,
  output logic [$clog2(LD_Q_DEPTH):0]         ld_count_wb
);

  localparam int LW = NUM_LANES * R_DATA_WIDTH;
  localparam int PW = $clog2(LD_Q_DEPTH);
  localparam int CW = PW + 1;

  logic [R_DATA_WIDTH-1:0] imm_ext;
  logic [LW-1:0]           exec_data;
  logic                    ex_we;

  generate
    if (IMM_SEXT != 0) begin : g_sext
      assign imm_ext = {{(R_DATA_WIDTH-IMM_WIDTH){imm_e[IMM_WIDTH-1]}}, imm_e};
    end else begin : g_zext
      assign imm_ext = {{(R_DATA_WIDTH-IMM_WIDTH){1'b0}}, imm_e};
    end
  endgenerate

  assign ex_we = control_e[0] & (|wmask_e);

  // Per-lane result select: [14:13] picks the unit, [10:9] the ALU op, [12] src1 vs imm.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      logic [R_DATA_WIDTH-1:0] lane_val;
      always_comb begin
        lane_val = '0;
        unique case (control_e[14:13])
          2'd0: begin
            unique case (control_e[10:9])
              2'd0: lane_val = mult_e[gi*R_DATA_WIDTH +: R_DATA_WIDTH];
              2'd1: lane_val = add_e[gi*R_DATA_WIDTH +: R_DATA_WIDTH];
              2'd2: lane_val = shift_e[gi*R_DATA_WIDTH +: R_DATA_WIDTH];
              2'd3: lane_val = logical_e[gi*R_DATA_WIDTH +: R_DATA_WIDTH];
            endcase
          end
          2'd1: lane_val = compare_e[gi*R_DATA_WIDTH +: R_DATA_WIDTH];
          2'd2: lane_val = control_e[12] ? imm_ext : src1_e[gi*R_DATA_WIDTH +: R_DATA_WIDTH];
          2'd3: lane_val = const_e;
        endcase
      end
      assign exec_data[gi*R_DATA_WIDTH +: R_DATA_WIDTH] = lane_val;
    end
  endgenerate

  // Load-return queue storage; pointers wrap naturally since depth is a power of two.
  logic [LW-1:0]        q_data [LD_Q_DEPTH];
  logic [NUM_LANES-1:0] q_mask [LD_Q_DEPTH];
  logic [WARP_BITS-1:0] q_warp [LD_Q_DEPTH];
  logic [REG_BITS-1:0]  q_rd   [LD_Q_DEPTH];

  logic [PW-1:0] head_reg, head_next;
  logic [PW-1:0] tail_reg, tail_next;
  logic [CW-1:0] count_reg, count_next;

  logic push, pop, bypass, enq;

  assign ld_ready_wb = (count_reg < CW'(LD_Q_DEPTH));
  assign push        = ld_valid_m & ld_ready_wb;
  assign pop         = (count_reg != '0) & ~ex_we;

`ifdef WB_LD_BYPASS_EN
  assign bypass = push & (count_reg == '0) & ~ex_we;
`else
  assign bypass = 1'b0;
`endif

  assign enq = push & ~bypass;

  always_comb begin
    head_next  = head_reg;
    tail_next  = tail_reg;
    count_next = count_reg;
    if (enq) tail_next = tail_reg + PW'(1);
    if (pop) head_next = head_reg + PW'(1);
    case ({enq, pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      q_data[tail_reg] <= ld_data_m;
      q_mask[tail_reg] <= ld_mask_m;
      q_warp[tail_reg] <= ld_warp_m;
      q_rd[tail_reg]   <= ld_rd_m;
    end
  end

  // Output register next-state: exec wins, then queue head, then bypassed return.
  logic [LW-1:0]        rdata_reg, rdata_next;
  logic [NUM_LANES-1:0] rwe_reg, rwe_next;
  logic [WARP_BITS-1:0] rwarp_reg, rwarp_next;
  logic [REG_BITS-1:0]  raddr_reg, raddr_next;

  always_comb begin
    rwe_next   = '0;
    rdata_next = rdata_reg;
    rwarp_next = rwarp_reg;
    raddr_next = raddr_reg;
    if (ex_we) begin
      rwe_next   = wmask_e;
      rdata_next = exec_data;
      rwarp_next = warp_e;
      raddr_next = rd_e;
    end else if (pop) begin
      rwe_next   = q_mask[head_reg];
      rdata_next = q_data[head_reg];
      rwarp_next = q_warp[head_reg];
      raddr_next = q_rd[head_reg];
    end else if (bypass) begin
      rwe_next   = ld_mask_m;
      rdata_next = ld_data_m;
      rwarp_next = ld_warp_m;
      raddr_next = ld_rd_m;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
      rwe_reg   <= '0;
      rdata_reg <= '0;
      rwarp_reg <= '0;
      raddr_reg <= '0;
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
      rwe_reg   <= rwe_next;
      rdata_reg <= rdata_next;
      rwarp_reg <= rwarp_next;
      raddr_reg <= raddr_next;
    end
  end

  assign rdata_wb    = rdata_reg;
  assign rwe_wb      = rwe_reg;
  assign rwarp_wb    = rwarp_reg;
  assign raddr_wb    = raddr_reg;
  assign ld_count_wb = count_reg;

endmodule
